// File: rtl/mips32_mem_arbiter.sv
// Arbiter sharing one unified word memory between the IF fetch port and the MEM load/store port.
// Define MIPS_ARB_RR_EN for round-robin arbitration; default is data priority with anti-starvation.
module mips32_mem_arbiter #(
    parameter int unsigned AW         = 10,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_if_req,
    input  logic [AW-1:0] i_if_addr,
    output logic          o_if_gnt,
    output logic          o_if_rvalid,
    output logic [31:0]   o_if_rdata,
    input  logic          i_d_req,
    input  logic          i_d_we,
    input  logic [AW-1:0] i_d_addr,
    input  logic [31:0]   i_d_wdata,
    output logic          o_d_gnt,
    output logic          o_d_rvalid,
    output logic [31:0]   o_d_rdata,
    input  logic          i_halted,
    output logic          o_stall_if,
    output logic          o_halt_done,
    output logic          o_mem_en,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [31:0]   o_mem_wdata,
    input  logic [31:0]   i_mem_rdata
);

    typedef enum logic [1:0] {StRun, StDrain, StHalt} state_e;

    typedef struct packed {
        logic valid;
        logic owner_d;
        logic we;
    } tag_t;

    state_e r_state;
    state_e w_state_next;
    tag_t   r_tag [MEM_LAT];
    tag_t   w_tag_in;
    tag_t   w_tag_out;
    logic   w_if_gnt;
    logic   w_d_gnt;
    logic   w_fetch_first;
    logic   w_pipe_busy;

`ifdef MIPS_ARB_RR_EN
    logic r_last_d;

    assign w_fetch_first = r_last_d;

    // Last-winner flag starts at "data" so fetch takes the first tie.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last_d <= 1'b1;
        end else if (w_if_gnt || w_d_gnt) begin
            r_last_d <= w_d_gnt;
        end
    end
`else
    localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

    logic [CntW-1:0] r_starve;
    logic [CntW-1:0] w_starve_next;
    logic            w_starve_full;

    assign w_starve_full = (r_starve == CntW'(STARVE_MAX));
    assign w_fetch_first = w_starve_full;

    always_comb begin
        w_starve_next = '0;
        if (i_if_req && !w_if_gnt) begin
            w_starve_next = w_starve_full ? r_starve : r_starve + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_starve <= '0;
        end else begin
            r_starve <= w_starve_next;
        end
    end
`endif

    // Grants drop immediately on reset, not at the next edge.
    always_comb begin
        w_if_gnt = 1'b0;
        w_d_gnt  = 1'b0;
        case (r_state)
            StRun: begin
                if (i_d_req && !(i_if_req && w_fetch_first)) begin
                    w_d_gnt = 1'b1;
                end else begin
                    w_if_gnt = i_if_req;
                end
            end
            StDrain: w_d_gnt = i_d_req;
            default: ;
        endcase
        if (i_rst) begin
            w_if_gnt = 1'b0;
            w_d_gnt  = 1'b0;
        end
    end

    // Busy means a tag survives past this edge; the exiting tag is answered this cycle.
    always_comb begin
        w_pipe_busy = 1'b0;
        for (int i = 0; i < int'(MEM_LAT) - 1; i++) begin
            w_pipe_busy = w_pipe_busy | r_tag[i].valid;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StRun:   if (i_halted) w_state_next = StDrain;
            StDrain: if (!w_pipe_busy && !i_d_req) w_state_next = StHalt;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StRun;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_tag_in         = '0;
        w_tag_in.valid   = w_if_gnt | w_d_gnt;
        w_tag_in.owner_d = w_d_gnt;
        w_tag_in.we      = w_d_gnt & i_d_we;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < int'(MEM_LAT); i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0] <= w_tag_in;
            for (int i = 1; i < int'(MEM_LAT); i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign w_tag_out = r_tag[MEM_LAT-1];

    assign o_if_gnt    = w_if_gnt;
    assign o_d_gnt     = w_d_gnt;
    assign o_stall_if  = i_if_req & ~w_if_gnt;
    assign o_halt_done = (r_state == StHalt);

    assign o_mem_en    = w_if_gnt | w_d_gnt;
    assign o_mem_we    = w_d_gnt & i_d_we;
    assign o_mem_addr  = w_d_gnt ? i_d_addr : (w_if_gnt ? i_if_addr : '0);
    assign o_mem_wdata = (w_d_gnt && i_d_we) ? i_d_wdata : '0;

    assign o_if_rvalid = w_tag_out.valid & ~w_tag_out.owner_d;
    assign o_d_rvalid  = w_tag_out.valid & w_tag_out.owner_d;
    assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
    assign o_d_rdata   = (o_d_rvalid && !w_tag_out.we) ? i_mem_rdata : '0;

endmodule
